freq_ratio_detector: RTL
========================

Name: freq_ratio_detector

Overview:
Receive-side companion to the frequency divider. Samples a divided clock (the divider's Q) in the system clk domain. Measures the period and high time in clk cycles, reports each measurement over a valid/ready interface, and asserts lock once the division ratio is stable. Used to check divider output in-system and as a self-check partner on the divider bench.

Parameters:
CNT_W, 16, width of the period/high counters and result outputs
LOCK_CNT, 4, number of consecutive equal periods required to assert locked (≥2)
SYNC_STAGES, 2, synchronizer flops on sig_in (≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
sig_in  input  1  divided signal under measurement; asynchronous to clk
period_o  output  CNT_W  measured period, in clk cycles between successive rising edges
high_o  output  CNT_W  clk cycles the synced signal was 1 within that period
meas_valid  output  1  result registers hold an unconsumed measurement
meas_ready  input  1  consumer accepts the result when meas_valid && meas_ready
locked  output  1  ratio stable
timeout  output  1  one-cycle pulse on counter saturation
drop  output  1  sticky: a measurement was discarded under backpressure

Behaviour:
- Reset (rst=0, async): all outputs 0; counters 0; FSM in IDLE.
- Synchronizer: SYNC_STAGES flops, then one delay flop. rise = sync & ~sync_d.
- FSM has three states:
  - IDLE: wait for rise, then go to MEASURE and load cnt=1 (high_cnt=1). No result is emitted for this first edge.
  - MEASURE: on each cycle without rise, cnt+=1 and high_cnt+=sync.
  - MEASURE on rise: capture cnt→period, high_cnt→high; reload cnt=1 and high_cnt=1; stay in MEASURE.
  - MEASURE, cnt reaches 2^CNT_W−1 with no rise: pulse timeout, clear locked and the lock counter, go to IDLE.
- Latency: meas_valid rises SYNC_STAGES+2 clk edges after the first edge that samples sig_in high.
- Handshake (capture on rise):
  - If !meas_valid, or meas_valid && meas_ready in the same cycle: load period_o/high_o and set meas_valid.
  - If meas_valid && !meas_ready: keep the old result, discard the new one, set drop. drop clears only on reset.
  - meas_valid clears after a transfer when no capture occurs in that cycle.
  - Outputs are stable while meas_valid && !meas_ready.
- Lock uses every capture, including dropped ones:
  - Equal to the previous period: match_cnt+=1, saturating at LOCK_CNT−1. Otherwise match_cnt=0 and locked=0.
  - locked=1 the cycle after match_cnt reaches LOCK_CNT−1.
  - The first capture after IDLE has no predecessor and sets match_cnt=0.
- Rising edges must be ≥2 clk apart for accurate results. Faster input is undefined but must not hang the FSM.
- Reset mid-measurement aborts silently: no timeout pulse, no result.

Optional Feature:
FREQ_DUTY_CHECK_EN:
- Defined: adds output duty_err (1 bit, reset 0), registered with each capture. duty_err=1 when |2·high − period| > 1 (not 50% within one cycle). Computed at CNT_W+1 bits.
- Undefined: the port is absent and no comparator is built.

Decomposition:
- Package freq_pkg: FSM state enum (IDLE, MEASURE), CNT_W default, saturation constant.
- One sub-module, freq_edge_sync: SYNC_STAGES synchronizer + delay flop, outputs sync and rise. Reused by other async-input blocks.

Test Plan:
- sig_in from a divide-by-4 divider (2 high/2 low clk) → period_o=4, high_o=2 on every transfer; locked=1 after the 4th equal period (5th rise overall); timeout=0.
- Divide-by-5 (3 high/2 low) → period_o=5, high_o=3; with FREQ_DUTY_CHECK_EN, duty_err=0 (|6−5|=1). With 4 high/1 low, duty_err=1.
- meas_ready=0 for 3 periods at divide-by-4 → period_o/high_o hold the first result, drop=1. Then meas_ready=1 → one transfer, meas_valid drops, next capture loads normally.
- CNT_W=4, sig_in held 0 after lock → timeout pulses 15 cycles after the last rise; locked=0; FSM in IDLE. The next rise emits no result; the following rise does.
- Ratio change 4→6 while locked → locked falls at the first period=6 capture and re-asserts after 4 equal periods of 6.
- rst pulled low mid-period, then released → all outputs 0 immediately. The first post-reset rise emits nothing; the second emits a correct period.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency ratio detector and its helpers.
package freq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } freq_state_e;

  localparam int unsigned FREQ_CNT_W = 16;

  // All-ones value of a w-bit counter: the point at which a period measurement gives up.
  function automatic logic [31:0] freq_cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] FREQ_CNT_MAX = freq_cnt_max(FREQ_CNT_W);

endpackage

// File: rtl/freq_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus a delay flop for rising-edge detect.
// sync_o and rise_o are both registered and therefore aligned to the same clk cycle.
module freq_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic                   sync_d_q;
  logic                   rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q  <= '0;
      sync_d_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      stage_q  <= {stage_q[SYNC_STAGES-2:0], async_i};
      sync_d_q <= stage_q[SYNC_STAGES-1];
      rise_q   <= stage_q[SYNC_STAGES-1] & ~sync_d_q;
    end
  end

  assign sync_o = sync_d_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/freq_ratio_detector.sv
// Measures period and high time of an asynchronous divided clock in clk cycles, with lock detect.
// Define FREQ_DUTY_CHECK_EN to add the duty_err output (50% duty check per delivered measurement).
module freq_ratio_detector
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W       = FREQ_CNT_W,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             locked,
  output logic             timeout,
  output logic             drop
`ifdef FREQ_DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam int unsigned      MATCH_W   = $clog2(LOCK_CNT);
  localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(freq_cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic sync;
  logic rise;

  freq_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .async_i(sig_in),
    .sync_o (sync),
    .rise_o (rise)
  );

  freq_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               timeout_q, timeout_d;
  logic               drop_q, drop_d;
  logic               first_q, first_d;
  logic               capture;
  logic               load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      prev_q     <= '0;
      match_q    <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cnt_q <= high_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cnt_d = high_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    prev_d     = prev_q;
    match_d    = match_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    drop_d     = drop_q;
    first_d    = first_q;
    capture    = 1'b0;
    load       = 1'b0;
    // Lock follows one cycle after the match counter tops out; later clears override this.
    locked_d   = locked_q | (match_q == MATCH_TOP);

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = MEASURE;
          cnt_d      = CNT_ONE;
          high_cnt_d = CNT_ONE;
          first_d    = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture    = 1'b1;
          cnt_d      = CNT_ONE;
          high_cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d  = 1'b1;
          state_d    = IDLE;
          locked_d   = 1'b0;
          match_d    = '0;
          cnt_d      = '0;
          high_cnt_d = '0;
        end else begin
          cnt_d      = cnt_q + CNT_ONE;
          high_cnt_d = high_cnt_q + CNT_W'(sync);
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end

    if (capture) begin
      load    = !valid_q || meas_ready;
      prev_d  = cnt_q;
      first_d = 1'b0;
      if (load) begin
        period_d = cnt_q;
        high_d   = high_cnt_q;
        valid_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
      // Every capture feeds lock detection, including those dropped under backpressure.
      if (first_q) begin
        match_d  = '0;
        locked_d = 1'b0;
      end else if (cnt_q == prev_q) begin
        if (match_q != MATCH_TOP) begin
          match_d = match_q + MATCH_ONE;
        end
      end else begin
        match_d  = '0;
        locked_d = 1'b0;
      end
    end
  end

  assign period_o   = period_q;
  assign high_o     = high_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
  assign drop       = drop_q;

`ifdef FREQ_DUTY_CHECK_EN
  localparam int unsigned DW = CNT_W + 1;

  logic          duty_q, duty_d;
  logic [DW-1:0] twice_high;
  logic [DW-1:0] period_ext;
  logic [DW-1:0] duty_diff;

  always_comb begin
    twice_high = {high_cnt_q, 1'b0};
    period_ext = {1'b0, cnt_q};
    duty_diff  = (twice_high >= period_ext) ? (twice_high - period_ext)
                                            : (period_ext - twice_high);
    duty_d     = duty_q;
    if (load) begin
      duty_d = (duty_diff > DW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_err = duty_q;
`endif

endmodule
